// File: rtl/resizer_pkg.sv
// Shared types and constants for the image-resizer coordinate path.
package resizer_pkg;

  localparam int unsigned SW_W   = 5;
  localparam int unsigned TW_W   = 6;
  localparam int unsigned CRD_W  = 7;
  localparam int unsigned FRAC_W = 8;

  // Q0.8 unity; its log2 is the number of fraction quotient bits.
  localparam int unsigned FRAC_ONE  = 256;
  localparam int unsigned FRAC_ITER = $clog2(FRAC_ONE);

  localparam int unsigned DIV_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FRAC,
    OUT,
    STEP,
    DONE
  } fcg_state_e;

endpackage

// File: rtl/frac_coord_gen_serial_div.sv
// Restoring serial divider, one quotient bit per cycle.
// The partial remainder is seeded with init_rem_i and dividend bits are
// shifted in MSB-first from a left-aligned dividend_i, iter_i times.
module serial_div #(
  parameter int unsigned Q_W   = 8,
  parameter int unsigned R_W   = 6,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [R_W-1:0]   divisor_i,
  input  logic [R_W-1:0]   init_rem_i,
  input  logic [Q_W-1:0]   dividend_i,
  input  logic [CNT_W-1:0] iter_i,
  output logic             valid_o,
  output logic [Q_W-1:0]   quot_o,
  output logic [R_W-1:0]   rem_o
);

  logic [R_W-1:0]   dvs_q;
  logic [R_W-1:0]   prem_q, prem_d;
  logic [Q_W-1:0]   dvd_q;
  logic [Q_W-1:0]   quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [R_W:0]     trial;
  logic [R_W:0]     diff;
  logic             ge;

  // One restoring step: trial subtract, keep the difference if non-negative.
  always_comb begin
    trial  = {prem_q, dvd_q[Q_W-1]};
    diff   = trial - {1'b0, dvs_q};
    ge     = (trial >= {1'b0, dvs_q});
    prem_d = ge ? diff[R_W-1:0] : trial[R_W-1:0];
  end

  // Load on start, then iterate until the count is exhausted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dvs_q  <= '0;
      prem_q <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      dvs_q  <= divisor_i;
      prem_q <= init_rem_i;
      dvd_q  <= dividend_i;
      quo_q  <= '0;
      cnt_q  <= iter_i;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        prem_q <= prem_d;
        dvd_q  <= {dvd_q[Q_W-2:0], 1'b0};
        quo_q  <= {quo_q[Q_W-2:0], ge};
        cnt_q  <= cnt_q - CNT_W'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign valid_o = busy_q && (cnt_q == '0);
  assign quot_o  = quo_q;
  assign rem_o   = prem_q;

endmodule

// File: rtl/frac_coord_gen.sv
// Per-axis source coordinate / Q0.8 fraction generator for t*(S-1)/(T-1),
// stepped incrementally; a shared serial divider supplies step constants
// and the per-sample fraction.
module frac_coord_gen #(
  parameter int unsigned SW_W   = resizer_pkg::SW_W,
  parameter int unsigned TW_W   = resizer_pkg::TW_W,
  parameter int unsigned CRD_W  = resizer_pkg::CRD_W,
  parameter int unsigned FRAC_W = resizer_pkg::FRAC_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [SW_W-1:0]   S,
  input  logic [TW_W-1:0]   T,
  input  logic [CRD_W-1:0]  origin,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CRD_W-1:0]  out_coord,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_on_grid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import resizer_pkg::*;

  fcg_state_e state_q, state_d;

  logic [TW_W-1:0]   t_q, t_d;
  logic [SW_W-1:0]   quot_q, quot_d;
  logic [TW_W-1:0]   rem_q, rem_d;
  logic [TW_W-1:0]   dd_q, dd_d;
  logic [SW_W-1:0]   stq_q, stq_d;
  logic [TW_W-1:0]   str_q, str_d;
  logic [CRD_W-1:0]  org_q, org_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              frun_q, frun_d;

  logic [TW_W:0]     rsum;
  logic [TW_W:0]     rsub;
  logic              carry;

  logic                 div_start;
  logic [TW_W-1:0]      div_divisor;
  logic [TW_W-1:0]      div_init;
  logic [FRAC_W-1:0]    div_dvd;
  logic [DIV_CNT_W-1:0] div_iter;
  logic                 div_valid;
  logic [FRAC_W-1:0]    div_quot;
  logic [TW_W-1:0]      div_rem;

  serial_div #(
    .Q_W   (FRAC_W),
    .R_W   (TW_W),
    .CNT_W (DIV_CNT_W)
  ) u_div (
    .clk_i      (CLK),
    .rst_i      (RST),
    .start_i    (div_start),
    .divisor_i  (div_divisor),
    .init_rem_i (div_init),
    .dividend_i (div_dvd),
    .iter_i     (div_iter),
    .valid_o    (div_valid),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // State and walk registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      t_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dd_q    <= '0;
      stq_q   <= '0;
      str_q   <= '0;
      org_q   <= '0;
      frac_q  <= '0;
      frun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dd_q    <= dd_d;
      stq_q   <= stq_d;
      str_q   <= str_d;
      org_q   <= org_d;
      frac_q  <= frac_d;
      frun_q  <= frun_d;
    end
  end

  // Remainder stepping: rem + step_r may exceed D once, then carries into quot.
  always_comb begin
    rsum  = {1'b0, rem_q} + {1'b0, str_q};
    rsub  = rsum - {1'b0, dd_q};
    carry = (rsum >= {1'b0, dd_q});
  end

  // Next-state and datapath update, including divider launch.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dd_d        = dd_q;
    stq_d       = stq_q;
    str_d       = str_q;
    org_d       = org_q;
    frac_d      = frac_q;
    frun_d      = frun_q;
    div_start   = 1'b0;
    div_divisor = dd_q;
    div_init    = rem_q;
    div_dvd     = '0;
    div_iter    = DIV_CNT_W'(FRAC_ITER);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          org_d       = origin;
          dd_d        = T - TW_W'(1);
          t_d         = '0;
          quot_d      = '0;
          rem_d       = '0;
          frac_d      = '0;
          frun_d      = 1'b0;
          // Step constants: (S-1)/(T-1), dividend left-aligned for the shifter.
          div_start   = 1'b1;
          div_divisor = T - TW_W'(1);
          div_init    = '0;
          div_dvd     = FRAC_W'(S - SW_W'(1)) << (FRAC_W - SW_W);
          div_iter    = DIV_CNT_W'(SW_W);
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (div_valid) begin
          if (dd_q == '0) begin
            stq_d = '0;
            str_d = '0;
          end else begin
            stq_d = div_quot[SW_W-1:0];
            str_d = div_rem;
          end
          state_d = FRAC;
        end
      end
      FRAC: begin
        if (rem_q == '0) begin
          frac_d  = '0;
          state_d = OUT;
        end else if (!frun_q) begin
          // Fraction: seed remainder with rem, shift in FRAC_ITER zero bits.
          div_start = 1'b1;
          frun_d    = 1'b1;
        end else if (div_valid) begin
          frac_d  = div_quot;
          frun_d  = 1'b0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = STEP;
      end
      STEP: begin
        if (t_q == dd_q) begin
          state_d = DONE;
        end else begin
          t_d     = t_q + TW_W'(1);
          quot_d  = quot_q + stq_q + SW_W'(carry);
          rem_d   = carry ? rsub[TW_W-1:0] : rsum[TW_W-1:0];
          state_d = FRAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; sample fields are zero outside OUT.
  always_comb begin
    out_valid   = 1'b0;
    out_coord   = '0;
    out_frac    = '0;
    out_on_grid = 1'b0;
    out_last    = 1'b0;
    busy        = (state_q == SETUP) || (state_q == FRAC) ||
                  (state_q == OUT)   || (state_q == STEP);
    done        = (state_q == DONE);
    if (state_q == OUT) begin
      out_valid   = 1'b1;
      out_coord   = org_q + CRD_W'(quot_q);
      out_frac    = frac_q;
      out_on_grid = (rem_q == '0);
      out_last    = (t_q == dd_q);
    end
  end

endmodule

// File: tb/tb_frac_coord_gen.sv
// Scoreboard bench for frac_coord_gen: expected samples come from a direct
// t*(S-1)/(T-1) computation and are checked on each accepted handshake.
module tb_frac_coord_gen;

  import resizer_pkg::*;

  typedef struct packed {
    logic [CRD_W-1:0]  coord;
    logic [FRAC_W-1:0] frac;
    logic              grid;
    logic              last;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [SW_W-1:0]   S = '0;
  logic [TW_W-1:0]   T = '0;
  logic [CRD_W-1:0]  origin = '0;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [CRD_W-1:0]  out_coord;
  logic [FRAC_W-1:0] out_frac;
  logic              out_on_grid;
  logic              out_last;
  logic              busy;
  logic              done;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned acc = 0;

  frac_coord_gen #(
    .SW_W   (SW_W),
    .TW_W   (TW_W),
    .CRD_W  (CRD_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .S           (S),
    .T           (T),
    .origin      (origin),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_coord   (out_coord),
    .out_frac    (out_frac),
    .out_on_grid (out_on_grid),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact quotient/remainder of t*N/D for every target index.
  task automatic push_walk(input int s, input int t, input int o);
    int n, d, q, r;
    exp_t e;
    n = s - 1;
    d = t - 1;
    for (int i = 0; i < t; i++) begin
      q = (d == 0) ? 0 : (i * n) / d;
      r = (d == 0) ? 0 : (i * n) % d;
      e.coord = CRD_W'((o + q) % 128);
      e.frac  = FRAC_W'((d == 0) ? 0 : (r * 256) / d);
      e.grid  = (r == 0);
      e.last  = (i == t - 1);
      sb.push_back(e);
    end
  endtask

  // Pop and compare on every accepted handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("extra_sample", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("coord", 32'(out_coord), 32'(e.coord));
        check("frac", 32'(out_frac), 32'(e.frac));
        check("on_grid", 32'(out_on_grid), 32'(e.grid));
        check("last", 32'(out_last), 32'(e.last));
      end
      acc++;
    end
  end

  task automatic do_start(input int s, input int t, input int o);
    @(posedge CLK);
    #1;
    S      = SW_W'(s);
    T      = TW_W'(t);
    origin = CRD_W'(o);
    start  = 1'b1;
    push_walk(s, t, o);
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_acc(input int unsigned n);
    for (int i = 0; i < 2000 && acc < n; i++) @(negedge CLK);
    if (acc < n) check("wait_acc_timeout", acc, n);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge CLK);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    int unsigned base;

    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_coord", 32'(out_coord), 32'd0);
    check("rst_frac", 32'(out_frac), 32'd0);
    check("rst_grid", 32'(out_on_grid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Upscale 4 -> 7
    do_start(4, 7, 10);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("up4_7");

    // Downscale 5 -> 4 with carry on the last step
    do_start(5, 4, 0);
    wait_done("down5_4");

    // Single target sample
    do_start(9, 1, 50);
    wait_done("t1");

    // S == 1 and S == T edge cases
    do_start(1, 5, 7);
    wait_done("s1");
    do_start(6, 6, 100);
    wait_done("s_eq_t");

    // Back-pressure: hold the second sample for 20 cycles
    base = acc;
    do_start(4, 7, 10);
    wait_acc(base + 1);
    @(posedge CLK);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) @(negedge CLK);
    repeat (20) begin
      @(negedge CLK);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_coord", 32'(out_coord), 32'd10);
      check("hold_frac", 32'(out_frac), 32'h80);
    end
    @(posedge CLK);
    #1 out_ready = 1'b1;
    wait_done("hold");
    check("hold_count", acc - base, 32'd7);

    // Asynchronous reset inside a multi-cycle FRAC
    base = acc;
    do_start(5, 4, 0);
    wait_acc(base + 2);
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_coord", 32'(out_coord), 32'd0);
    check("arst_frac", 32'(out_frac), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    sb.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    do_start(3, 3, 20);
    wait_done("after_rst");

    // Start while busy is ignored
    base = acc;
    do_start(5, 4, 3);
    wait_acc(base + 1);
    @(posedge CLK);
    #1;
    S      = SW_W'(9);
    T      = TW_W'(9);
    origin = '0;
    start  = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    wait_done("ign_start");
    check("ign_count", acc - base, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
